// File: rtl/spi_pkg.sv
// Shared SPI ADC definitions: frame geometry and the FSM state encoding,
// common to the responder and the matching master.
package spi_pkg;
   localparam int DATA_W     = 13;
   localparam int LEAD_BITS  = 3;
   localparam int FRAME_BITS = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      TAIL  = 2'd2
   } spi_state_t;
endpackage

// File: rtl/spi_adc_responder_if.sv
// SPI pins plus the sample-word handshake and per-frame status pulses.
interface spi_adc_responder_if #(parameter int DATA_W = spi_pkg::DATA_W);
   logic              nCS;
   logic              sck;
   logic              miso;
   logic              miso_oe;
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              frame_done;
   logic              frame_abort;
   logic              underrun;

   modport slave (
      input  nCS, sck, din, din_valid,
      output miso, miso_oe, din_ready, frame_done, frame_abort, underrun
   );

   modport master (
      output nCS, sck, din, din_valid,
      input  miso, miso_oe, din_ready, frame_done, frame_abort, underrun
   );
endinterface

// File: rtl/sync_edge.sv
// 2-FF synchroniser for an asynchronous pin with registered rise/fall pulses;
// a pulse appears 3 clk after the pin edge.
module sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);
   logic s1, s2, s3;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1   <= RST_VAL;
         s2   <= RST_VAL;
         s3   <= RST_VAL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= d;
         s2   <= s1;
         s3   <= s2;
         rise <= s2 & ~s3;
         fall <= ~s2 & s3;
      end
   end
endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder emulating the 13-bit serial ADC: serialises buffered sample
// words MSB-first behind LEAD_BITS zeros, one word per nCS frame.
module spi_adc_responder
   import spi_pkg::*;
#(
   parameter int DATA_W     = spi_pkg::DATA_W,
   parameter int LEAD_BITS  = spi_pkg::LEAD_BITS,
   parameter int FRAME_BITS = spi_pkg::FRAME_BITS
) (
   input  logic                clk,
   input  logic                rst,
   spi_adc_responder_if.slave  bus
);
   localparam int CW = $clog2(FRAME_BITS);

   logic ncs_rise, ncs_fall, sck_fall, sck_rise_unused;

   sync_edge #(.RST_VAL(1'b1)) u_ncs (
      .clk(clk), .rst(rst), .d(bus.nCS), .rise(ncs_rise), .fall(ncs_fall)
   );

   sync_edge #(.RST_VAL(1'b0)) u_sck (
      .clk(clk), .rst(rst), .d(bus.sck), .rise(sck_rise_unused), .fall(sck_fall)
   );

   spi_state_t            state;
   logic [FRAME_BITS-1:0] shreg;
   logic [CW-1:0]         bit_cnt;
   logic [DATA_W-1:0]     buf_q;
   logic [DATA_W-1:0]     last_sample;
   logic [DATA_W-1:0]     load_word;
   logic                  buf_full;
   logic                  bypass;

   assign bus.din_ready = !buf_full;

   // An empty buffer with a word on din at frame start hands it straight to
   // the shifter, so the buffer must not capture it as well.
   assign bypass = (state == IDLE) && ncs_fall && !buf_full && bus.din_valid;

   always_comb begin
      load_word = last_sample;
      if (buf_full)           load_word = buf_q;
      else if (bus.din_valid) load_word = bus.din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         shreg           <= '0;
         bit_cnt         <= '0;
         buf_q           <= '0;
         buf_full        <= 1'b0;
         last_sample     <= '0;
         bus.miso        <= 1'b0;
         bus.miso_oe     <= 1'b0;
         bus.frame_done  <= 1'b0;
         bus.frame_abort <= 1'b0;
         bus.underrun    <= 1'b0;
      end else begin
         bus.frame_done  <= 1'b0;
         bus.frame_abort <= 1'b0;
         bus.underrun    <= 1'b0;

         if (bus.din_valid && !buf_full && !bypass) begin
            buf_q    <= bus.din;
            buf_full <= 1'b1;
         end

         case (state)
            IDLE: begin
               bus.miso    <= 1'b0;
               bus.miso_oe <= 1'b0;
               if (ncs_fall) begin
                  shreg       <= {{LEAD_BITS{1'b0}}, load_word};
                  last_sample <= load_word;
                  bit_cnt     <= '0;
                  bus.miso_oe <= 1'b1;
                  state       <= SHIFT;
                  if (buf_full)            buf_full     <= 1'b0;
                  else if (!bus.din_valid) bus.underrun <= 1'b1;
               end
            end

            SHIFT, TAIL: begin
               // Deselect takes priority over a coincident sck fall.
               if (ncs_rise) begin
                  state       <= IDLE;
                  bus.miso    <= 1'b0;
                  bus.miso_oe <= 1'b0;
                  if (state == TAIL) bus.frame_done  <= 1'b1;
                  else               bus.frame_abort <= 1'b1;
               end else if (sck_fall) begin
                  if (state == SHIFT) begin
                     shreg    <= shreg << 1;
                     bus.miso <= shreg[FRAME_BITS-2];
                     bit_cnt  <= bit_cnt + CW'(1);
                     if (bit_cnt == CW'(FRAME_BITS-2)) state <= TAIL;
                  end else begin
                     bus.miso <= 1'b0;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_adc_responder.sv
// Randomised bench for spi_adc_responder: a pin-level SPI master drives frames,
// a reference model predicts each frame, a monitor scores frame ends.
module tb_spi_adc_responder;
   import spi_pkg::*;

   typedef struct {
      bit                done;
      int                n;
      logic [DATA_W-1:0] w;
      bit                und;
   } exp_t;

   logic clk, rst;
   spi_adc_responder_if bus ();

   spi_adc_responder dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #31 clk = ~clk;

   int errors = 0;
   int checks = 0;
   exp_t exp_q[$];

   // reference model: one-entry buffer plus the last word sent
   logic [DATA_W-1:0] mbuf;
   bit                mbuf_v;
   logic [DATA_W-1:0] mlast;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wclk(input int k);
      repeat (k) @(posedge clk);
      #7;
   endtask

   task automatic write(input logic [DATA_W-1:0] w);
      int tmo;
      mbuf   = w;
      mbuf_v = 1'b1;
      @(negedge clk);
      bus.din       = w;
      bus.din_valid = 1'b1;
      tmo = 0;
      while (!bus.din_ready && tmo < 200) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 200) chk("write_timeout", 1, 0);
      @(negedge clk);
      bus.din_valid = 1'b0;
   endtask

   // n sck pulses with half-period hp clk; byp presents bw exactly in the load cycle
   task automatic frame(input int n, input int hp, input bit byp, input logic [DATA_W-1:0] bw);
      exp_t e;
      int   tmo;
      if (byp) begin
         e.w = bw;  e.und = 1'b0;
      end else if (mbuf_v) begin
         e.w = mbuf; e.und = 1'b0; mbuf_v = 1'b0;
      end else begin
         e.w = mlast; e.und = 1'b1;
      end
      mlast  = e.w;
      e.n    = n;
      e.done = (n >= FRAME_BITS - 1);
      exp_q.push_back(e);

      @(negedge clk);
      chk("oe_before_cs", bus.miso_oe, 0);
      wclk(1);
      bus.nCS = 1'b0;
      if (byp) begin
         repeat (3) @(posedge clk);
         #1 bus.din = bw; bus.din_valid = 1'b1;
         @(posedge clk);
         #1 bus.din_valid = 1'b0;
      end
      wclk(6);
      chk("oe_selected", bus.miso_oe, 1);
      chk("ready_after_load", bus.din_ready, 1);
      for (int i = 0; i < n; i++) begin
         bus.sck = 1'b1; wclk(hp);
         bus.sck = 1'b0; wclk(hp);
      end
      bus.nCS = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("oe_after_cs_rise", bus.miso_oe, 0);
      chk("miso_after_cs_rise", bus.miso, 0);
      tmo = 0;
      while (exp_q.size() != 0 && tmo < 8) begin
         @(negedge clk); #2;
         tmo++;
      end
      chk("frame_end_seen", exp_q.size(), 0);
      exp_q.delete();
      wclk(4);
   endtask

   // monitor: captures miso on sck rise, scores every frame end against the queue
   logic [FRAME_BITS-1:0] rx;
   int  rxn, und_cnt;
   logic prev_ncs = 1'b1, prev_sck = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      logic [FRAME_BITS-1:0] fw, eb;
      if (!bus.nCS && prev_ncs) begin
         rx = '0; rxn = 0; und_cnt = 0;
      end
      if (bus.sck && !prev_sck && !bus.nCS) begin
         rx = {rx[FRAME_BITS-2:0], bus.miso};
         rxn++;
      end
      if (bus.underrun) und_cnt++;
      if (bus.frame_done || bus.frame_abort) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_frame_end", {bus.frame_done, bus.frame_abort}, 0);
         end else begin
            e  = exp_q.pop_front();
            fw = FRAME_BITS'(e.w);
            eb = (e.n == 0) ? '0 : fw >> (FRAME_BITS - e.n);
            chk("end_is_done", bus.frame_done, e.done);
            chk("end_is_abort", bus.frame_abort, !e.done);
            chk("bits_seen", rxn, e.n);
            chk("frame_data", rx, eb);
            chk("underrun_count", und_cnt, e.und);
         end
      end
      prev_ncs = bus.nCS;
      prev_sck = bus.sck;
   end

   initial begin
      #(62 * 60000);
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      bus.nCS = 1'b1; bus.sck = 1'b0;
      bus.din = '0;   bus.din_valid = 1'b0;
      mbuf = '0; mbuf_v = 1'b0; mlast = '0;
      repeat (3) @(negedge clk);
      chk("rst_miso", bus.miso, 0);
      chk("rst_oe", bus.miso_oe, 0);
      chk("rst_ready", bus.din_ready, 1);
      chk("rst_pulses", {bus.frame_done, bus.frame_abort, bus.underrun}, 0);
      rst = 1'b1;
      wclk(3);

      // single frame at 1 MHz
      write(13'h1ABC);
      chk("ready_when_full", bus.din_ready, 0);
      frame(16, 8, 1'b0, '0);

      // back-to-back with a mid-frame write
      write(13'h0001);
      fork
         frame(16, 8, 1'b0, '0);
         begin wclk(60); write(13'h1FFF); end
      join
      frame(16, 8, 1'b0, '0);

      // underrun re-sends the last word
      write(13'h0A5A);
      frame(16, 8, 1'b0, '0);
      frame(16, 8, 1'b0, '0);

      // bypass, then confirm the buffer stayed empty
      frame(16, 8, 1'b1, 13'h1234);
      frame(16, 8, 1'b0, '0);

      // abort after 8 clocks, next frame takes the next buffered word
      write(13'h0777);
      frame(8, 8, 1'b0, '0);
      write(13'h0555);
      frame(16, 8, 1'b0, '0);

      // reset mid-frame at bit 6
      write(13'h1FFF);
      @(negedge clk);
      wclk(1);
      bus.nCS = 1'b0;
      wclk(6);
      for (int i = 0; i < 6; i++) begin
         bus.sck = 1'b1; wclk(8);
         bus.sck = 1'b0; wclk(8);
      end
      chk("pre_reset_miso", bus.miso, 1);
      #5 rst = 1'b0;
      #1;
      chk("async_rst_miso", bus.miso, 0);
      chk("async_rst_oe", bus.miso_oe, 0);
      bus.nCS = 1'b1;
      mbuf_v = 1'b0; mlast = '0;
      wclk(3);
      rst = 1'b1;
      wclk(2);
      chk("post_rst_ready", bus.din_ready, 1);
      frame(16, 8, 1'b0, '0);

      // randomised traffic
      for (int it = 0; it < 24; it++) begin
         int n, hp;
         if (!mbuf_v && ($urandom % 4 != 0)) write(13'($urandom_range(8191, 0)));
         hp = $urandom_range(10, 5);
         if ($urandom % 4 == 0) n = $urandom_range(14, 0);
         else n = ($urandom % 5 == 0) ? 15 : 16;
         frame(n, hp, 1'b0, '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/spi_adc_responder.md
Name: spi_adc_responder

Overview:
- SPI responder (slave) that emulates the 13-bit serial ADC read by the team's SPI master: drives miso in response to nCS/sck from the master.
- Sample words arrive on a parallel valid/ready port from a system-side producer (pattern generator, DMA, loopback) and are serialised MSB-first per frame.
- Used as a drop-in stand-in for the ADC in FPGA loopback and system tests. All logic runs on the single 16 MHz clk, and nCS/sck are oversampled.

Parameters:
- DATA_W, 13, sample width in bits.
- LEAD_BITS, 3, leading zero bits before data MSB (2 sample-phase bits + 1 null bit).
- FRAME_BITS, 16, total bits per frame; must equal LEAD_BITS+DATA_W.

Ports:
- clk  in  1  system clock, 16 MHz.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- nCS  in  1  chip select from master, active-low, asynchronous to clk.
- sck  in  1  serial clock from master, idle low, asynchronous to clk.
- miso  out  1  serial data to master.
- miso_oe  out  1  output enable for the miso pad tristate; 1 only while selected.
- din  in  DATA_W  next sample word.
- din_valid  in  1  din is valid.
- din_ready  out  1  holding buffer can accept a word.
- frame_done  out  1  one-cycle pulse: frame completed normally.
- frame_abort  out  1  one-cycle pulse: nCS deasserted before all bits were shifted.
- underrun  out  1  one-cycle pulse: frame started with an empty buffer, so the last sample was re-sent.

Behaviour:
- Reset (rst=0, asynchronous, effective mid-frame as well):
  - miso=0, miso_oe=0, din_ready=1, all pulses 0.
  - Buffer empty, last_sample=0, state IDLE, synchronisers set to idle (nCS=1, sck=0).
- Input conditioning: nCS and sck each pass through a 2-FF synchroniser plus edge detector. Edge pulses appear 3 clk after the pin edge.
- sck timing requirement: high and low phases each >= 4 clk (sck <= 2 MHz at 16 MHz clk).
- Data is updated on sck falling edges, and the master samples on rising edges.
  - miso must change no more than 4 clk after a pin-level sck fall.
  - This guarantees setup before the next rise.
- Holding buffer (1 entry):
  - A word is accepted when din_valid && din_ready. din_ready = !buf_full.
- States: IDLE, SHIFT, TAIL.
- IDLE: miso_oe=0, miso=0. On synchronised nCS fall, load the shift register and go to SHIFT. The load source is chosen as follows:
  - buffer full: use the buffer word, clear buf_full.
  - buffer empty and din_valid in the same cycle: bypass, use din directly, assert din_ready that cycle, buffer stays empty.
  - otherwise: use last_sample and pulse underrun.
  - In every case, the loaded word becomes the new last_sample.
- Shift register value is {LEAD_BITS zeros, word}, FRAME_BITS wide.
  - On load, miso_oe=1 and miso = MSB of the register, which is 0.
- SHIFT:
  - Each synchronised sck fall shifts left by 1 and increments bit_cnt (width clog2(FRAME_BITS)).
  - miso always shows the register MSB.
  - After the (FRAME_BITS-1)th fall, the word LSB is on miso and the state goes to TAIL.
- TAIL: further sck falls drive miso=0 with no wrap, and the counter saturates.
- nCS rise (synchronised) in SHIFT or TAIL: go to IDLE with miso_oe=0, miso=0.
  - From TAIL: pulse frame_done.
  - From SHIFT: pulse frame_abort. The consumed word is not restored.
- nCS rise and sck fall detected in the same cycle: the nCS rise wins and no shift occurs.
- sck edges while nCS is high are ignored.
- The buffer may be written during any state, including mid-frame.
- Result: master frame of 16 clocks gives 3 zeros followed by din[12]..din[0], so the master's 13-bit Dout equals the sent word.

Decomposition:
- Shared package spi_pkg: DATA_W, LEAD_BITS, FRAME_BITS defaults, and the state encoding (IDLE/SHIFT/TAIL) reused by the master for consistency.
- One sub-module, sync_edge: 2-FF synchroniser with rise/fall pulse outputs and a parameterised reset value. It is instantiated for nCS (reset 1) and sck (reset 0).

Test Plan:
- Idle output: write din=13'h1ABC, then master reads one 16-clock frame at 1 MHz sck. Master Dout=13'h1ABC, frame_done pulses once, miso_oe low outside nCS, din_ready returns to 1 on load.
- Back-to-back frames: preload 13'h0001, then write 13'h1FFF mid-frame. Frame1=0x0001 and frame2=0x1FFF with no underrun.
- Underrun: no new write after 13'h0A5A is sent. The second frame re-sends 0x0A5A and underrun pulses exactly once at the second nCS fall.
- Bypass: buffer empty, din_valid asserted with 13'h1234 in the exact cycle of the synchronised nCS fall. Frame carries 0x1234, no underrun, buffer stays empty.
- Abort: nCS raised after 8 sck clocks. frame_abort pulses, miso_oe=0 within 4 clk, and the next frame uses the next buffered word rather than repeating the aborted one.
- Reset mid-frame: rst=0 at bit 6. miso and miso_oe go 0 immediately without a clk edge. After release, din_ready=1 and a new frame with no write returns 0x0000 with underrun.
